// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, FSM state type and operand field helpers for the FPU multiply server.
package fpu_pkg;
    localparam int CExpLenDef = 8;
    localparam int CMantLenDef = 28;
    localparam logic [63:0] ZERO_WORD = '0;
    typedef enum logic [1:0] {IDLE, MUL, NORM, ACK} state_t;
    function automatic int f_bias(input int el);
        return (1 << (el - 1)) - 1;
    endfunction
    // Word layout is {sign, exp[el], mant[ml]}, right-aligned in 64 bits.
    function automatic logic f_sign(input logic [63:0] w, input int el, input int ml);
        return w[el + ml];
    endfunction
    function automatic logic [63:0] f_exp(input logic [63:0] w, input int el, input int ml);
        return (w >> ml) & ((64'd1 << el) - 64'd1);
    endfunction
    function automatic logic [63:0] f_mant(input logic [63:0] w, input int ml);
        return w & ((64'd1 << ml) - 64'd1);
    endfunction
endpackage

// File: rtl/fpu_mul_server_if.sv
// fpu_mul_server_if: Req/Ack operand channel between an initiator and the multiply server.
interface fpu_mul_server_if
    import fpu_pkg::*;
#(
    parameter int CExpLen = CExpLenDef,
    parameter int CMantLen = CMantLenDef
) ();
    localparam int W = 1 + CExpLen + CMantLen;
    logic AReq;
    logic [W-1:0] ADataS;
    logic [W-1:0] ADataU;
    logic [W-1:0] ADataR;
    logic AAck;
    logic ABusy;
    logic AErr;
    modport master (output AReq, ADataS, ADataU, input ADataR, AAck, ABusy, AErr);
    modport slave (input AReq, ADataS, ADataU, output ADataR, AAck, ABusy, AErr);
endinterface

// File: rtl/fpu_mul_pack.sv
// fpu_mul_pack: turns operand sign/exponent and the top product bits into a packed, saturated result.
module fpu_mul_pack
    import fpu_pkg::*;
#(
    parameter int CExpLen = CExpLenDef,
    parameter int CMantLen = CMantLenDef
) (
    input  logic [CExpLen:0]            i_hdr_s,
    input  logic [CExpLen:0]            i_hdr_u,
    input  logic [CMantLen:0]           i_prod_hi,
    output logic [CExpLen+CMantLen:0]   o_res
);
    localparam int E = CExpLen;
    localparam int M = CMantLen;
    localparam int W = 1 + E + M;
    localparam int EB = E + 2;
    localparam logic [EB-1:0] EMAX = EB'((1 << E) - 1);
    logic w_sign;
    logic w_zero;
    logic w_ovf;
    logic w_unf;
    logic [EB-1:0] w_e;
    logic [M-1:0] w_mant;
    // i_prod_hi holds product bits [2M-1:M-1]; the MSB selects the normalisation shift.
    always_comb begin
        w_sign = i_hdr_s[E] ^ i_hdr_u[E];
        w_zero = (i_hdr_s[E-1:0] == '0) || (i_hdr_u[E-1:0] == '0);
        w_e = EB'(i_hdr_s[E-1:0]) + EB'(i_hdr_u[E-1:0]) - EB'(f_bias(E)) + EB'(i_prod_hi[M]);
        w_mant = i_prod_hi[M] ? i_prod_hi[M:1] : i_prod_hi[M-1:0];
        w_unf = w_e[EB-1] || (w_e == '0);
        w_ovf = !w_e[EB-1] && (w_e >= EMAX);
        o_res = (w_zero || w_unf) ? W'(ZERO_WORD)
              : w_ovf ? {w_sign, E'((1 << E) - 2), {M{1'b1}}}
              : {w_sign, w_e[E-1:0], w_mant};
    end
endmodule

// File: rtl/fpu_mul_server.sv
// fpu_mul_server: iterative shift-add floating-point multiplier serving one Req/Ack operand channel,
// with a one-entry skid register so a request can arrive while a multiply is in flight.
module fpu_mul_server
    import fpu_pkg::*;
#(
    parameter int CExpLen = CExpLenDef,
    parameter int CMantLen = CMantLenDef
) (
    input  logic AClkH,
    input  logic AResetH,
    input  logic AClkHEn,
    fpu_mul_server_if.slave bus
);
    localparam int E = CExpLen;
    localparam int M = CMantLen;
    localparam int W = 1 + E + M;
    localparam int CW = $clog2(M);
    state_t r_state;
    state_t w_nxt;
    logic [CW-1:0] r_cnt;
    logic [M:0] r_acc;
    logic [M-1:0] r_mpl;
    logic [M-1:0] r_mcand;
    logic [E:0] r_hdr_s;
    logic [E:0] r_hdr_u;
    logic [W-1:0] r_skid_s;
    logic [W-1:0] r_skid_u;
    logic [W-1:0] r_data;
    logic r_skid_v;
    logic r_ack;
    logic r_err;
    logic w_load;
    logic w_from_skid;
    logic w_cap;
    logic w_drop;
    logic [W-1:0] w_src_s;
    logic [W-1:0] w_src_u;
    logic [W-1:0] w_res;
    logic [M:0] w_sum;
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) r_state <= IDLE;
        else if (AClkHEn) r_state <= w_nxt;
    end
    always_comb begin
        w_nxt = r_state;
        w_load = 1'b0;
        w_from_skid = 1'b0;
        w_cap = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt = bus.AReq ? MUL : IDLE;
                w_load = bus.AReq;
            end
            MUL, NORM: begin
                w_nxt = (r_state == NORM) ? ACK : (r_cnt == '0) ? NORM : MUL;
                w_cap = bus.AReq && !r_skid_v;
                w_drop = bus.AReq && r_skid_v;
            end
            default: begin
                // A waiting skid entry has priority; a simultaneous request refills the skid.
                w_nxt = (r_skid_v || bus.AReq) ? MUL : IDLE;
                w_load = r_skid_v || bus.AReq;
                w_from_skid = r_skid_v;
                w_cap = r_skid_v && bus.AReq;
            end
        endcase
    end
    assign w_src_s = w_from_skid ? r_skid_s : bus.ADataS;
    assign w_src_u = w_from_skid ? r_skid_u : bus.ADataU;
    // r_acc keeps only product bits [2M-1:M-1]; lower bits are dropped by truncation anyway.
    assign w_sum = {1'b0, r_acc[M:1]} + {1'b0, r_mpl[0] ? r_mcand : M'(0)};
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_mpl <= '0;
            r_mcand <= '0;
            r_hdr_s <= '0;
            r_hdr_u <= '0;
            r_skid_s <= '0;
            r_skid_u <= '0;
            r_skid_v <= 1'b0;
            r_data <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else if (AClkHEn) begin
            r_ack <= r_state == NORM;
            r_err <= r_err | w_drop;
            r_skid_v <= w_cap | (r_skid_v & ~w_from_skid);
            if (w_cap) begin
                r_skid_s <= bus.ADataS;
                r_skid_u <= bus.ADataU;
            end
            if (r_state == NORM) r_data <= w_res;
            if (w_load) begin
                r_hdr_s <= {f_sign(64'(w_src_s), E, M), E'(f_exp(64'(w_src_s), E, M))};
                r_hdr_u <= {f_sign(64'(w_src_u), E, M), E'(f_exp(64'(w_src_u), E, M))};
                r_mcand <= M'(f_mant(64'(w_src_s), M));
                r_mpl <= M'(f_mant(64'(w_src_u), M));
                r_acc <= '0;
                r_cnt <= CW'(M - 1);
            end else if (r_state == MUL) begin
                r_acc <= w_sum;
                r_mpl <= r_mpl >> 1;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
    fpu_mul_pack #(.CExpLen(CExpLen), .CMantLen(CMantLen)) u_pack (
        .i_hdr_s   (r_hdr_s),
        .i_hdr_u   (r_hdr_u),
        .i_prod_hi (r_acc),
        .o_res     (w_res)
    );
    assign bus.ADataR = r_data;
    assign bus.AAck = r_ack;
    assign bus.ABusy = (r_state != IDLE) || r_skid_v;
    assign bus.AErr = r_err;
endmodule

// File: tb/tb_fpu_mul_server.sv
// tb_fpu_mul_server: directed and randomized checks of fpu_mul_server against an arithmetic reference model.
module tb_fpu_mul_server;
    localparam int W = 37;
    typedef logic [W-1:0] word_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    int checks = 0;
    int failures = 0;
    fpu_mul_server_if bus();
    fpu_mul_server dut (.AClkH(clk), .AResetH(rst), .AClkHEn(en), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    // Value-level model: real product of mantissas, exponent arithmetic on ints, then saturation.
    function automatic word_t ref_mul(word_t s, word_t u);
        int es = int'(s[35:28]);
        int eu = int'(u[35:28]);
        longint unsigned p = longint'(s[27:0]) * longint'(u[27:0]);
        logic sg = s[36] ^ u[36];
        int e;
        logic [27:0] m;
        if (es == 0 || eu == 0) return '0;
        e = es + eu - 127;
        if (p[55]) begin
            m = p[55:28];
            e++;
        end else m = p[54:27];
        if (e >= 255) return {sg, 8'hFE, 28'hFFFFFFF};
        if (e <= 0) return '0;
        return {sg, e[7:0], m};
    endfunction
    function automatic word_t rnd_op();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 254));
        return {1'($urandom_range(0, 1)), e, 1'b1, 27'($urandom)};
    endfunction
    task automatic do_op(input string tag, input word_t s, input word_t u, input word_t exp);
        int n;
        bus.AReq = 1'b1;
        bus.ADataS = s;
        bus.ADataU = u;
        tick;
        bus.AReq = 1'b0;
        bus.ADataS = word_t'($urandom);
        bus.ADataU = word_t'($urandom);
        n = 1;
        while (bus.AAck !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd30);
        chk({tag, "_data"}, 64'(bus.ADataR), 64'(exp));
        tick;
    endtask
    initial begin
        word_t s, u, held;
        word_t bs[5];
        word_t bu[5];
        int at[5] = '{0, 30, 35, 40, 60};
        word_t q[$];
        int n, acks;
        bus.AReq = 1'b0;
        bus.ADataS = '0;
        bus.ADataU = '0;
        #1;
        chk("reset_data", 64'(bus.ADataR), 64'd0);
        chk("reset_ack", 64'(bus.AAck), 64'd0);
        chk("reset_busy", 64'(bus.ABusy), 64'd0);
        chk("reset_err", 64'(bus.AErr), 64'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        do_op("one_x_two", {1'b0, 8'h7F, 28'h8000000}, {1'b0, 8'h80, 28'h8000000}, {1'b0, 8'h80, 28'h8000000});
        do_op("onehalf_sq", {1'b0, 8'h7F, 28'hC000000}, {1'b0, 8'h7F, 28'hC000000}, {1'b0, 8'h80, 28'h9000000});
        do_op("one_x_one", {1'b0, 8'h7F, 28'h8000000}, {1'b0, 8'h7F, 28'h8000000}, {1'b0, 8'h7F, 28'h8000000});
        do_op("neg_one", {1'b1, 8'h7F, 28'h8000000}, {1'b0, 8'h7F, 28'h8000000}, {1'b1, 8'h7F, 28'h8000000});
        do_op("zero_x_three", '0, {1'b0, 8'h80, 28'hC000000}, '0);
        do_op("overflow", {1'b0, 8'hFE, 28'h8000000}, {1'b0, 8'hFE, 28'h8000000}, {1'b0, 8'hFE, 28'hFFFFFFF});
        chk("overflow_err", 64'(bus.AErr), 64'd0);
        do_op("underflow", {1'b0, 8'h01, 28'h8000000}, {1'b0, 8'h01, 28'h8000000}, '0);
        for (int i = 0; i < 10; i++) begin
            s = rnd_op();
            u = rnd_op();
            do_op("random", s, u, ref_mul(s, u));
            repeat ($urandom_range(0, 3)) tick;
        end
        // Back-to-back: ACK-cycle request, skid fill, drop, and skid+request in a later ACK cycle.
        for (int i = 0; i < 5; i++) begin
            bs[i] = rnd_op();
            bu[i] = rnd_op();
            if (i != 3) q.push_back(ref_mul(bs[i], bu[i]));
        end
        for (int c = 0; c < 125; c++) begin
            bus.AReq = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (c == at[i]) begin
                    bus.AReq = 1'b1;
                    bus.ADataS = bs[i];
                    bus.ADataU = bu[i];
                end
            end
            tick;
            chk("b2b_ack", 64'(bus.AAck), 64'(c == 29 || c == 59 || c == 89 || c == 119));
            if (bus.AAck === 1'b1 && q.size() > 0) chk("b2b_data", 64'(bus.ADataR), 64'(q.pop_front()));
            if (c == 39 || c == 40) chk("b2b_err", 64'(bus.AErr), 64'(c == 40));
            if (c == 36) chk("b2b_busy", 64'(bus.ABusy), 64'd1);
        end
        chk("b2b_drained", 64'(q.size()), 64'd0);
        chk("b2b_idle", 64'(bus.ABusy), 64'd0);
        bus.AReq = 1'b1;
        bus.ADataS = {1'b0, 8'h7F, 28'hC000000};
        bus.ADataU = {1'b0, 8'h7F, 28'hC000000};
        tick;
        bus.AReq = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.ABusy), 64'd0);
        chk("rst_data", 64'(bus.ADataR), 64'd0);
        chk("rst_err", 64'(bus.AErr), 64'd0);
        tick;
        rst = 1'b0;
        acks = 0;
        repeat (35) begin
            tick;
            if (bus.AAck === 1'b1) acks++;
        end
        chk("rst_no_ack", 64'(acks), 64'd0);
        do_op("after_rst", {1'b0, 8'h7F, 28'h8000000}, {1'b0, 8'h80, 28'h8000000}, {1'b0, 8'h80, 28'h8000000});
        s = {1'b0, 8'h85, 1'b1, 27'($urandom)};
        u = {1'b1, 8'h70, 1'b1, 27'($urandom)};
        bus.AReq = 1'b1;
        bus.ADataS = s;
        bus.ADataU = u;
        tick;
        bus.AReq = 1'b0;
        n = 1;
        repeat (4) begin
            tick;
            n++;
        end
        en = 1'b0;
        repeat (5) begin
            tick;
            n++;
        end
        en = 1'b1;
        while (bus.AAck !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk("clken_latency", 64'(n), 64'd35);
        chk("clken_data", 64'(bus.ADataR), 64'(ref_mul(s, u)));
        held = bus.ADataR;
        en = 1'b0;
        tick;
        tick;
        chk("clken_ack_held", 64'(bus.AAck), 64'd1);
        chk("clken_data_held", 64'(bus.ADataR), 64'(held));
        en = 1'b1;
        tick;
        chk("clken_ack_done", 64'(bus.AAck), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
